// File: rtl/ftb_update_unit.sv
// FTQ->BPU commit-update responder: read-modify-write of one FTB entry per committed block.
// Optional FTB_UPDATE_FASTALLOC_EN: blocks that missed at predict time allocate without reading.
module ftb_update_unit #(
  parameter int XLEN      = 64,
  parameter int FTB_IDX_W = 9,
  parameter int FTB_TAG_W = 16,
  parameter int FT_OFF_W  = 6,
  parameter int BT_W      = 3,
  parameter int ENT_W     = 1 + FTB_TAG_W + FT_OFF_W + XLEN + BT_W + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_bpu_commit,
  input  logic [XLEN-1:0]      i_startAddr,
  input  logic [XLEN-1:0]      i_fallthruAddr,
  input  logic [XLEN-1:0]      i_targetAddr,
  input  logic [BT_W-1:0]      i_branch_type,
  input  logic                 i_taken,
  input  logic                 i_mispred,
  input  logic                 i_hit_on_ftb,
  output logic                 o_bpu_update_finished,
  output logic                 o_ftb_rd_en,
  output logic [FTB_IDX_W-1:0] o_ftb_rd_idx,
  input  logic [ENT_W-1:0]     i_ftb_rd_data,
  output logic                 o_ftb_wr_en,
  output logic [FTB_IDX_W-1:0] o_ftb_wr_idx,
  output logic [ENT_W-1:0]     o_ftb_wr_data
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RESP, S_WR, S_DONE} state_t;

  typedef struct packed {
    logic                 valid;
    logic [FTB_TAG_W-1:0] tag;
    logic [FT_OFF_W-1:0]  ftoff;
    logic [XLEN-1:0]      target;
    logic [BT_W-1:0]      btype;
    logic [1:0]           ctr;
  } ent_t;

  function automatic ent_t f_alloc(input logic [FTB_TAG_W-1:0] tag, input logic [FT_OFF_W-1:0] off,
                                   input logic [XLEN-1:0] tgt, input logic [BT_W-1:0] bt,
                                   input logic tk);
    ent_t e;
    e.valid  = 1'b1;
    e.tag    = tag;
    e.ftoff  = off;
    e.target = tgt;
    e.btype  = bt;
    e.ctr    = tk ? 2'd2 : 2'd1;
    return e;
  endfunction

  state_t               r_state;
  logic [FTB_IDX_W-1:0] r_idx;
  logic [FTB_TAG_W-1:0] r_tag;
  logic [FT_OFF_W-1:0]  r_ftoff;
  logic [XLEN-1:0]      r_target;
  logic [BT_W-1:0]      r_btype;
  logic                 r_taken;
  logic                 r_mispred;
  logic                 r_fin;
  logic                 r_rd_en;
  logic [FTB_IDX_W-1:0] r_rd_idx;
  logic                 r_wr_en;
  logic [FTB_IDX_W-1:0] r_wr_idx;
  ent_t                 r_wr_data;

  logic [FTB_IDX_W-1:0] w_in_idx;
  logic [FTB_TAG_W-1:0] w_in_tag;
  logic [FT_OFF_W-1:0]  w_in_off;
  ent_t                 w_rd;
  ent_t                 w_new;
  logic                 w_hit;
  logic                 w_need_wr;
  logic                 w_unused_addr;

  assign w_in_idx = i_startAddr[FTB_IDX_W+1:2];
  assign w_in_tag = i_startAddr[FTB_TAG_W+FTB_IDX_W+1:FTB_IDX_W+2];
  // Truncated difference only needs the low bits of each address.
  assign w_in_off = i_fallthruAddr[FT_OFF_W-1:0] - i_startAddr[FT_OFF_W-1:0];
  assign w_unused_addr = ^{i_startAddr[XLEN-1:FTB_TAG_W+FTB_IDX_W+2], i_startAddr[1:0],
                           i_fallthruAddr[XLEN-1:FT_OFF_W]};

`ifdef FTB_UPDATE_FASTALLOC_EN
  logic w_in_alloc;
  assign w_in_alloc = (i_branch_type != '0) && (i_taken || i_mispred);
`else
  logic w_unused_hit;
  assign w_unused_hit = i_hit_on_ftb;
`endif

  assign w_rd  = ent_t'(i_ftb_rd_data);
  assign w_hit = w_rd.valid && (w_rd.tag == r_tag);

  always_comb begin
    w_new     = w_rd;
    w_need_wr = 1'b0;
    if (r_btype != '0) begin
      if (w_hit) begin
        if (r_taken && w_rd.ctr != 2'd3)       w_new.ctr = w_rd.ctr + 2'd1;
        else if (!r_taken && w_rd.ctr != 2'd0) w_new.ctr = w_rd.ctr - 2'd1;
        if (r_taken) w_new.target = r_target;
        if (r_mispred) begin
          w_new.ftoff = r_ftoff;
          w_new.btype = r_btype;
        end
        // A saturated, otherwise identical entry is left alone.
        w_need_wr = (w_new != w_rd);
      end else if (r_taken || r_mispred) begin
        w_new     = f_alloc(r_tag, r_ftoff, r_target, r_btype, r_taken);
        w_need_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_tag     <= '0;
      r_ftoff   <= '0;
      r_target  <= '0;
      r_btype   <= '0;
      r_taken   <= 1'b0;
      r_mispred <= 1'b0;
      r_fin     <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_idx  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
    end else begin
      r_fin     <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_idx  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
      case (r_state)
        S_IDLE: if (i_bpu_commit) begin
          r_idx     <= w_in_idx;
          r_tag     <= w_in_tag;
          r_ftoff   <= w_in_off;
          r_target  <= i_targetAddr;
          r_btype   <= i_branch_type;
          r_taken   <= i_taken;
          r_mispred <= i_mispred;
`ifdef FTB_UPDATE_FASTALLOC_EN
          if (!i_hit_on_ftb) begin
            if (w_in_alloc) begin
              r_state   <= S_WR;
              r_wr_en   <= 1'b1;
              r_wr_idx  <= w_in_idx;
              r_wr_data <= f_alloc(w_in_tag, w_in_off, i_targetAddr, i_branch_type, i_taken);
            end else begin
              r_state <= S_DONE;
              r_fin   <= 1'b1;
            end
          end else begin
            r_state  <= S_RD;
            r_rd_en  <= 1'b1;
            r_rd_idx <= w_in_idx;
          end
`else
          r_state  <= S_RD;
          r_rd_en  <= 1'b1;
          r_rd_idx <= w_in_idx;
`endif
        end
        S_RD: r_state <= S_RESP;
        S_RESP: if (w_need_wr) begin
          r_state   <= S_WR;
          r_wr_en   <= 1'b1;
          r_wr_idx  <= r_idx;
          r_wr_data <= w_new;
        end else begin
          r_state <= S_DONE;
          r_fin   <= 1'b1;
        end
        S_WR: begin
          r_state <= S_DONE;
          r_fin   <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_bpu_update_finished = r_fin;
  assign o_ftb_rd_en           = r_rd_en;
  assign o_ftb_rd_idx          = r_rd_idx;
  assign o_ftb_wr_en           = r_wr_en;
  assign o_ftb_wr_idx          = r_wr_idx;
  assign o_ftb_wr_data         = r_wr_data;

endmodule

// File: tb/tb_ftb_update_unit.sv
// Directed bench for ftb_update_unit with a one-entry SRAM model returning data a cycle after rd_en.
module tb_ftb_update_unit;
  localparam int ENT_W = 92;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              commit = 1'b0;
  logic [63:0]       sa = '0, fa = '0, ta = '0;
  logic [2:0]        bt = '0;
  logic              tk = 1'b0, mp = 1'b0, hit_ftb = 1'b1;
  logic              fin, rd_en, wr_en;
  logic [8:0]        rd_idx, wr_idx;
  logic [ENT_W-1:0]  rd_q = '0, wr_data, sram_ent = '0;

  int n_pass = 0;
  int n_tot  = 0;

  ftb_update_unit dut (
    .clk(clk), .rst(rst), .i_bpu_commit(commit),
    .i_startAddr(sa), .i_fallthruAddr(fa), .i_targetAddr(ta),
    .i_branch_type(bt), .i_taken(tk), .i_mispred(mp), .i_hit_on_ftb(hit_ftb),
    .o_bpu_update_finished(fin), .o_ftb_rd_en(rd_en), .o_ftb_rd_idx(rd_idx),
    .i_ftb_rd_data(rd_q), .o_ftb_wr_en(wr_en), .o_ftb_wr_idx(wr_idx),
    .o_ftb_wr_data(wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_q <= sram_ent;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [ENT_W-1:0] ent(input logic v, input logic [15:0] tag, input logic [5:0] off,
                                           input logic [63:0] tgt, input logic [2:0] b, input logic [1:0] c);
    return {v, tag, off, tgt, b, c};
  endfunction

  // One update over an 8-cycle window; cycle n is T+n relative to the commit edge.
  task automatic do_update(input logic [63:0] s, f, t, input logic [2:0] b, input logic k, m, h,
                           input logic [ENT_W-1:0] e,
                           output int rd_c, wr_c, fin_c, fin_n,
                           output logic [8:0] ridx, widx, output logic [ENT_W-1:0] wd);
    rd_c = 0; wr_c = 0; fin_c = 0; fin_n = 0; ridx = '0; widx = '0; wd = '0;
    sa = s; fa = f; ta = t; bt = b; tk = k; mp = m; hit_ftb = h; sram_ent = e;
    commit = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); @(negedge clk);
      if (rd_en) begin rd_c = n; ridx = rd_idx; end
      if (wr_en) begin wr_c = n; widx = wr_idx; wd = wr_data; end
      if (fin) begin
        fin_n++;
        if (fin_c == 0) fin_c = n;
        commit = 1'b0;
      end
    end
    commit = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_tot++;
    if ({fin, rd_en, wr_en, rd_idx, wr_idx, wr_data} !== '0)
      $display("FAIL reset_outputs got fin=%b rd=%b wr=%b want all zero", fin, rd_en, wr_en);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_miss_alloc;
    int rc, wc, fc, fn; logic [8:0] ri, wi; logic [ENT_W-1:0] wd;
    logic [ENT_W-1:0] exp_e;
    exp_e = ent(1'b1, 16'h0000, 6'h10, 64'h8000_2000, 3'd1, 2'd2);
    do_update(64'h8000_0100, 64'h8000_0110, 64'h8000_2000, 3'd1, 1'b1, 1'b0, 1'b1, '0,
              rc, wc, fc, fn, ri, wi, wd);
    n_tot++; if (rc !== 1 || ri !== 9'h040) $display("FAIL alloc_rd got cyc=%0d idx=%h want 1 040", rc, ri); else n_pass++;
    n_tot++; if (wc !== 3 || wi !== 9'h040) $display("FAIL alloc_wr got cyc=%0d idx=%h want 3 040", wc, wi); else n_pass++;
    n_tot++; if (wd !== exp_e) $display("FAIL alloc_data got %h want %h", wd, exp_e); else n_pass++;
    n_tot++; if (fc !== 4 || fn !== 1) $display("FAIL alloc_fin got cyc=%0d cnt=%0d want 4 1", fc, fn); else n_pass++;
  endtask

  task automatic test_hit_saturated;
    int rc, wc, fc, fn; logic [8:0] ri, wi; logic [ENT_W-1:0] wd;
    do_update(64'h8000_0100, 64'h8000_0110, 64'h8000_2000, 3'd1, 1'b1, 1'b0, 1'b1,
              ent(1'b1, 16'h0000, 6'h10, 64'h8000_2000, 3'd1, 2'd3), rc, wc, fc, fn, ri, wi, wd);
    n_tot++; if (wc !== 0 || fc !== 3 || fn !== 1)
      $display("FAIL hit_sat3 got wr=%0d fin=%0d cnt=%0d want 0 3 1", wc, fc, fn); else n_pass++;
    do_update(64'h0001_2344, 64'h0001_2350, 64'h5000, 3'd2, 1'b0, 1'b0, 1'b1,
              ent(1'b1, 16'h0024, 6'h0C, 64'h7000, 3'd2, 2'd0), rc, wc, fc, fn, ri, wi, wd);
    n_tot++; if (rc !== 1 || ri !== 9'h0D1 || wc !== 0 || fc !== 3)
      $display("FAIL hit_sat0 got rd=%0d idx=%h wr=%0d fin=%0d want 1 0d1 0 3", rc, ri, wc, fc); else n_pass++;
  endtask

  task automatic test_hit_update;
    int rc, wc, fc, fn; logic [8:0] ri, wi; logic [ENT_W-1:0] wd;
    logic [ENT_W-1:0] exp_e;
    exp_e = ent(1'b1, 16'h0024, 6'h0C, 64'h7000, 3'd2, 2'd1);
    do_update(64'h0001_2344, 64'h0001_2350, 64'h5000, 3'd2, 1'b0, 1'b0, 1'b1,
              ent(1'b1, 16'h0024, 6'h0C, 64'h7000, 3'd2, 2'd2), rc, wc, fc, fn, ri, wi, wd);
    n_tot++; if (wc !== 3 || wi !== 9'h0D1 || wd !== exp_e || fc !== 4)
      $display("FAIL hit_dec got wr=%0d idx=%h data=%h fin=%0d want 3 0d1 %h 4", wc, wi, wd, fc, exp_e); else n_pass++;
    exp_e = ent(1'b1, 16'h0024, 6'h0C, 64'h5000, 3'd2, 2'd2);
    do_update(64'h0001_2344, 64'h0001_2350, 64'h5000, 3'd2, 1'b1, 1'b1, 1'b1,
              ent(1'b1, 16'h0024, 6'h3F, 64'h1234, 3'd5, 2'd1), rc, wc, fc, fn, ri, wi, wd);
    n_tot++; if (wc !== 3 || wd !== exp_e)
      $display("FAIL hit_mispred got wr=%0d data=%h want 3 %h", wc, wd, exp_e); else n_pass++;
  endtask

  task automatic test_miss_cases;
    int rc, wc, fc, fn; logic [8:0] ri, wi; logic [ENT_W-1:0] wd;
    logic [ENT_W-1:0] exp_e;
    do_update(64'h0001_2344, 64'h0001_2350, 64'h5000, 3'd2, 1'b0, 1'b0, 1'b1,
              ent(1'b1, 16'h0025, 6'h0C, 64'h7000, 3'd2, 2'd2), rc, wc, fc, fn, ri, wi, wd);
    n_tot++; if (wc !== 0 || fc !== 3) $display("FAIL miss_nt got wr=%0d fin=%0d want 0 3", wc, fc); else n_pass++;
    exp_e = ent(1'b1, 16'h0024, 6'h0C, 64'h5000, 3'd2, 2'd1);
    do_update(64'h0001_2344, 64'h0001_2350, 64'h5000, 3'd2, 1'b0, 1'b1, 1'b1,
              ent(1'b1, 16'h0025, 6'h0C, 64'h7000, 3'd2, 2'd2), rc, wc, fc, fn, ri, wi, wd);
    n_tot++; if (wc !== 3 || wd !== exp_e || fc !== 4)
      $display("FAIL miss_mp got wr=%0d data=%h fin=%0d want 3 %h 4", wc, wd, fc, exp_e); else n_pass++;
    do_update(64'h0001_2344, 64'h0001_2350, 64'h5000, 3'd0, 1'b1, 1'b1, 1'b1, '0,
              rc, wc, fc, fn, ri, wi, wd);
    n_tot++; if (wc !== 0 || fc !== 3) $display("FAIL btype0 got wr=%0d fin=%0d want 0 3", wc, fc); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int rc, wc, fc, fn; logic [8:0] ri, wi; logic [ENT_W-1:0] wd;
    logic saw_fin;
    saw_fin = 1'b0;
    sa = 64'h8000_0100; fa = 64'h8000_0110; ta = 64'h8000_2000; bt = 3'd1; tk = 1'b1; mp = 1'b0;
    hit_ftb = 1'b1; sram_ent = '0; commit = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); @(negedge clk);
      if (fin) saw_fin = 1'b1;
    end
    n_tot++; if (wr_en !== 1'b1) $display("FAIL rstmid_pre got wr=%b want 1", wr_en); else n_pass++;
    rst = 1'b1; #1;
    n_tot++; if (wr_en !== 1'b0 || fin !== 1'b0) $display("FAIL rstmid_abort got wr=%b fin=%b want 0 0", wr_en, fin); else n_pass++;
    @(posedge clk); @(negedge clk);
    if (fin) saw_fin = 1'b1;
    n_tot++; if (saw_fin !== 1'b0) $display("FAIL rstmid_nofin got %b want 0", saw_fin); else n_pass++;
    rst = 1'b0;
    do_update(64'h8000_0100, 64'h8000_0110, 64'h8000_2000, 3'd1, 1'b1, 1'b0, 1'b1, '0,
              rc, wc, fc, fn, ri, wi, wd);
    n_tot++; if (rc !== 1 || wc !== 3 || fc !== 4 || fn !== 1)
      $display("FAIL rstmid_redo got rd=%0d wr=%0d fin=%0d cnt=%0d want 1 3 4 1", rc, wc, fc, fn); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int f1, f2, fn, wn;
    f1 = 0; f2 = 0; fn = 0; wn = 0;
    sa = 64'h8000_0100; fa = 64'h8000_0110; ta = 64'h8000_2000; bt = 3'd1; tk = 1'b1; mp = 1'b0;
    hit_ftb = 1'b1; sram_ent = '0; commit = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); @(negedge clk);
      if (wr_en) wn++;
      if (fin) begin
        fn++;
        if (fn == 1) begin f1 = n; bt = 3'd0; end
        else begin f2 = n; commit = 1'b0; end
      end
    end
    commit = 1'b0;
    n_tot++; if (f1 !== 4 || f2 !== 8 || fn !== 2 || wn !== 1)
      $display("FAIL b2b got fin1=%0d fin2=%0d cnt=%0d wr=%0d want 4 8 2 1", f1, f2, fn, wn); else n_pass++;
  endtask

`ifdef FTB_UPDATE_FASTALLOC_EN
  task automatic test_fastalloc;
    int rc, wc, fc, fn; logic [8:0] ri, wi; logic [ENT_W-1:0] wd;
    logic [ENT_W-1:0] exp_e;
    exp_e = ent(1'b1, 16'h0000, 6'h10, 64'h8000_2000, 3'd1, 2'd2);
    do_update(64'h8000_0100, 64'h8000_0110, 64'h8000_2000, 3'd1, 1'b1, 1'b0, 1'b0, '0,
              rc, wc, fc, fn, ri, wi, wd);
    n_tot++; if (rc !== 0 || wc !== 1 || wi !== 9'h040 || wd !== exp_e || fc !== 2 || fn !== 1)
      $display("FAIL fastalloc got rd=%0d wr=%0d fin=%0d data=%h want 0 1 2 %h", rc, wc, fc, wd, exp_e); else n_pass++;
    do_update(64'h8000_0100, 64'h8000_0110, 64'h8000_2000, 3'd1, 1'b0, 1'b0, 1'b0, '0,
              rc, wc, fc, fn, ri, wi, wd);
    n_tot++; if (rc !== 0 || wc !== 0 || fc !== 1)
      $display("FAIL fast_nowr got rd=%0d wr=%0d fin=%0d want 0 0 1", rc, wc, fc); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_miss_alloc();
    test_hit_saturated();
    test_hit_update();
    test_miss_cases();
    test_reset_mid();
    test_back_to_back();
`ifdef FTB_UPDATE_FASTALLOC_EN
    test_fastalloc();
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
